demo_btn_sequencer: RTL and testbench

Front-end command generator that sits directly upstream of the bus demo top and drives its `start`/`mode` inputs from board buttons and switches. It synchronizes and debounces a raw push-button, converts each press into a single active-low `start` pulse, and tracks the downstream `ready` handshake. In auto mode it runs a scripted burst of alternating write/read commands. It also flags a stalled downstream with an error status.

---
 rtl/demo_btn_sequencer.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_demo_btn_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demo_btn_sequencer.sv
// demo_btn_sequencer
//   Button/switch front end for the bus demo. It synchronizes the raw board
//   inputs, debounces the go button, turns each accepted press into a single
//   active-low start strobe, and tracks the downstream ready handshake. In
//   auto mode one press runs a burst of SEQ_LEN commands that alternate write
//   and read, starting with a write. A stalled downstream sets a sticky err
//   flag, which the next press clears.
//
//   Build option: define DEMO_BTN_DEBOUNCE_EN to include the debouncer.
//   Without it the synchronized button is used directly as the accepted level.
//
// Parameters
//   DEBOUNCE_CYCLES  equal consecutive samples needed to accept a new level
//   SEQ_LEN          commands per auto burst (1..255)
//   READY_TIMEOUT    maximum cycles to wait for ready to return high
// Ports
//   clk          system clock
//   rst          asynchronous active-high reset
//   btn_go       raw push-button, active-low, asynchronous
//   btn_mode     raw switch, 1 = write, 0 = read, asynchronous
//   sw_auto      raw switch, 1 = burst mode, asynchronous
//   ready        downstream idle indication
//   start        active-low command strobe, low for one cycle per command
//   mode         command direction, 1 = write, 0 = read
//   busy         high while the FSM is not idle
//   err          sticky timeout flag
//   done_count   number of completed commands, wraps at 255

module demo_btn_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned SEQ_LEN         = 4,
    parameter int unsigned READY_TIMEOUT   = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_go,
    input  logic       btn_mode,
    input  logic       sw_auto,
    input  logic       ready,
    output logic       start,
    output logic       mode,
    output logic       busy,
    output logic       err,
    output logic [7:0] done_count
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_RDY,
        ERR
    } state_t;

    localparam logic [7:0]  SEQ_LEN8 = 8'(SEQ_LEN);
    localparam logic [15:0] TO_LAST  = 16'((READY_TIMEOUT == 0) ? 0 : READY_TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Input synchronizers. The go button resets to its released level so
    // that leaving reset never looks like a press.
    // ------------------------------------------------------------------
    logic [1:0] go_sync;
    logic [1:0] mode_sync;
    logic [1:0] auto_sync;
    logic       go_s;
    logic       mode_s;
    logic       auto_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            go_sync   <= '1;
            mode_sync <= '0;
            auto_sync <= '0;
        end else begin
            go_sync   <= {go_sync[0], btn_go};
            mode_sync <= {mode_sync[0], btn_mode};
            auto_sync <= {auto_sync[0], sw_auto};
        end
    end

    always_comb begin
        go_s   = go_sync[1];
        mode_s = mode_sync[1];
        auto_s = auto_sync[1];
    end

    // ------------------------------------------------------------------
    // Accepted button level
    // ------------------------------------------------------------------
    logic go_level;

`ifdef DEMO_BTN_DEBOUNCE_EN
    localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [DB_W-1:0] db_cnt;

    // The counter holds the length of the current run of samples that
    // differ from the accepted level; any sample matching it ends the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_cnt   <= '0;
            go_level <= 1'b1;
        end else if (go_s == go_level) begin
            db_cnt <= '0;
        end else if (db_cnt >= DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt   <= '0;
            go_level <= go_s;
        end else begin
            db_cnt <= db_cnt + 1'b1;
        end
    end
`else
    logic unused_db_cfg;

    always_comb begin
        go_level      = go_s;
        unused_db_cfg = ^32'(DEBOUNCE_CYCLES);
    end
`endif

    // One-cycle press on a 1->0 transition of the accepted level
    logic go_level_q;
    logic press;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            go_level_q <= 1'b1;
        end else begin
            go_level_q <= go_level;
        end
    end

    always_comb begin
        press = go_level_q & ~go_level;
    end

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    state_t      state;
    state_t      state_d;
    logic [7:0]  remaining;
    logic [7:0]  remaining_d;
    logic        cmd_par;       // parity of the index of the next command
    logic        cmd_par_d;
    logic        auto_lat;
    logic        auto_d;
    logic [1:0]  wb_cnt;
    logic [1:0]  wb_cnt_d;
    logic [15:0] timer;
    logic [15:0] timer_d;
    logic [7:0]  done_d;
    logic        mode_d;
    logic        start_d;
    logic        busy_d;
    logic        err_d;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (press && ready) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!ready) begin
                    state_d = WAIT_RDY;
                end else if (wb_cnt == 2'd3) begin
                    state_d = ERR;
                end
            end
            WAIT_RDY: begin
                // Completion is checked first so it wins over a coincident timeout
                if (ready) begin
                    state_d = (remaining <= 8'd1) ? IDLE : ISSUE;
                end else if (timer >= TO_LAST) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                if (press) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath logic. Every output is computed from the next
    // state and registered, so nothing reaches a port combinationally.
    always_comb begin
        remaining_d = remaining;
        cmd_par_d   = cmd_par;
        auto_d      = auto_lat;
        wb_cnt_d    = wb_cnt;
        timer_d     = timer;
        done_d      = done_count;
        mode_d      = mode;

        case (state)
            IDLE: begin
                if (state_d == ISSUE) begin
                    auto_d      = auto_s;
                    remaining_d = auto_s ? SEQ_LEN8 : 8'd1;
                    cmd_par_d   = 1'b0;
                end
            end
            WAIT_BUSY: begin
                wb_cnt_d = wb_cnt + 2'd1;
            end
            WAIT_RDY: begin
                if (ready) begin
                    done_d      = done_count + 8'd1;
                    remaining_d = remaining - 8'd1;
                    cmd_par_d   = ~cmd_par;
                end else begin
                    timer_d = timer + 16'd1;
                end
            end
            ERR: begin
                remaining_d = '0;
            end
            default: begin
            end
        endcase

        if (state_d == ISSUE) begin
            wb_cnt_d = '0;
            timer_d  = '0;
            mode_d   = auto_d ? ~cmd_par_d : mode_s;
        end

        start_d = (state_d != ISSUE);
        busy_d  = (state_d != IDLE);
        err_d   = (state_d == ERR);
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining  <= '0;
            cmd_par    <= 1'b0;
            auto_lat   <= 1'b0;
            wb_cnt     <= '0;
            timer      <= '0;
            done_count <= '0;
            mode       <= 1'b0;
            start      <= 1'b1;
            busy       <= 1'b0;
            err        <= 1'b0;
        end else begin
            remaining  <= remaining_d;
            cmd_par    <= cmd_par_d;
            auto_lat   <= auto_d;
            wb_cnt     <= wb_cnt_d;
            timer      <= timer_d;
            done_count <= done_d;
            mode       <= mode_d;
            start      <= start_d;
            busy       <= busy_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_demo_btn_sequencer.sv
// Testbench for demo_btn_sequencer. A downstream model drops ready one cycle
// after start falls and raises it five cycles later; expected command modes
// are queued as stimulus is driven and checked as each start pulse appears.

module tb_demo_btn_sequencer;

    localparam int unsigned DEB = 8;
    localparam int unsigned SEQ = 4;
    localparam int unsigned RTO = 20;
`ifdef DEMO_BTN_DEBOUNCE_EN
    localparam int unsigned LAT_MAX = DEB + 4;
`else
    localparam int unsigned LAT_MAX = 3;
`endif

    logic       clk;
    logic       rst;
    logic       btn_go;
    logic       btn_mode;
    logic       sw_auto;
    logic       ready;
    logic       start;
    logic       mode;
    logic       busy;
    logic       err;
    logic [7:0] done_count;

    int total = 0;
    int bad   = 0;

    logic exp_q[$];
    int   pulses = 0;

    demo_btn_sequencer #(
        .DEBOUNCE_CYCLES(DEB),
        .SEQ_LEN        (SEQ),
        .READY_TIMEOUT  (RTO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_go    (btn_go),
        .btn_mode  (btn_mode),
        .sw_auto   (sw_auto),
        .ready     (ready),
        .start     (start),
        .mode      (mode),
        .busy      (busy),
        .err       (err),
        .done_count(done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream model
    logic ready_r    = 1'b1;
    logic ds_prev    = 1'b1;
    logic hold_low   = 1'b0;
    logic force_high = 1'b0;
    int   ds_cnt     = 0;

    assign ready = force_high | ready_r;

    always @(posedge clk) begin
        ds_prev <= start;
        if (ds_prev && !start) begin
            ready_r <= 1'b0;
            ds_cnt  <= 5;
        end else if (ds_cnt != 0) begin
            ds_cnt <= ds_cnt - 1;
            if (ds_cnt == 1 && !hold_low) ready_r <= 1'b1;
        end else if (!hold_low && !ready_r) begin
            ready_r <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: one entry per start pulse
    logic mon_prev = 1'b1;

    always @(negedge clk) begin
        if (!rst && start === 1'b0) begin
            chk("start_one_cycle", 32'(mon_prev), 32'(1));
            chk("pulse_expected", 32'(exp_q.size() != 0), 32'(1));
            if (exp_q.size() != 0) chk("cmd_mode", 32'(mode), 32'(exp_q.pop_front()));
            pulses <= pulses + 1;
        end
        mon_prev <= rst ? 1'b1 : start;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int hold);
        btn_go = 1'b0;
        tick(hold);
        btn_go = 1'b1;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (busy !== 1'b0 && n < bound) begin
            tick(1);
            n++;
        end
        chk("idle_within_bound", 32'(busy), 32'(0));
    endtask

    task automatic wait_start_low(input int bound, output int lat);
        lat = 0;
        while (start !== 1'b0 && lat < bound) begin
            tick(1);
            lat++;
        end
        chk("start_seen", 32'(start), 32'(0));
    endtask

    task automatic wait_err(input logic val, input int bound, output int lat);
        lat = 0;
        while (err !== val && lat < bound) begin
            tick(1);
            lat++;
        end
        chk("err_reached", 32'(err), 32'(val));
    endtask

    int base;
    int lat;
    int n;

    initial begin
        btn_go   = 1'b1;
        btn_mode = 1'b0;
        sw_auto  = 1'b0;
        rst      = 1'b1;
        tick(3);
        chk("rst_start", 32'(start), 32'(1));
        chk("rst_mode", 32'(mode), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_done", 32'(done_count), 32'(0));
        rst = 1'b0;
        tick(3);

        // Single write
        btn_mode = 1'b1;
        base = pulses;
        exp_q.push_back(1'b1);
        btn_go = 1'b0;
        wait_start_low(40, lat);
        chk("press_latency_in_bound", 32'(lat <= LAT_MAX), 32'(1));
        tick(10);
        btn_go = 1'b1;
        wait_idle(60);
        tick(15);
        chk("single_pulses", 32'(pulses - base), 32'(1));
        chk("single_mode", 32'(mode), 32'(1));
        chk("single_done", 32'(done_count), 32'(1));
        chk("single_busy_after", 32'(busy), 32'(0));

        // Bounce rejection, then a clean read
        btn_mode = 1'b0;
        base = pulses;
        exp_q.push_back(1'b0);
`ifdef DEMO_BTN_DEBOUNCE_EN
        for (int i = 0; i < 7; i++) begin
            btn_go = 1'b0;
            tick(3);
            btn_go = 1'b1;
            tick(3);
        end
        chk("glitch_no_pulse", 32'(pulses - base), 32'(0));
        chk("glitch_not_busy", 32'(busy), 32'(0));
`endif
        press(20);
        wait_idle(60);
        tick(15);
        chk("bounce_pulses", 32'(pulses - base), 32'(1));
        chk("bounce_done", 32'(done_count), 32'(2));

        // Auto burst with switch changes and a second press mid-burst
        sw_auto = 1'b1;
        base = pulses;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        press(10);
        sw_auto  = 1'b0;
        btn_mode = 1'b1;
        tick(10);
        chk("burst_busy_mid", 32'(busy), 32'(1));
        press(10);
        wait_idle(120);
        tick(15);
        chk("burst_pulses", 32'(pulses - base), 32'(SEQ));
        chk("burst_done", 32'(done_count), 32'(6));
        chk("burst_last_mode", 32'(mode), 32'(0));
        chk("burst_queue_drained", 32'(exp_q.size()), 32'(0));

        // Ready timeout
        hold_low = 1'b1;
        btn_mode = 1'b1;
        base = pulses;
        exp_q.push_back(1'b1);
        btn_go = 1'b0;
        wait_start_low(40, lat);
        wait_err(1'b1, 60, lat);
        chk("timeout_delay_in_bound", 32'(lat >= RTO + 1 && lat <= RTO + 3), 32'(1));
        btn_go = 1'b1;
        tick(20);
        chk("timeout_no_more_pulses", 32'(pulses - base), 32'(1));
        chk("timeout_err_sticky", 32'(err), 32'(1));
        chk("timeout_busy_in_err", 32'(busy), 32'(1));
        chk("timeout_start_high", 32'(start), 32'(1));
        hold_low = 1'b0;
        tick(3);
        press(12);
        wait_err(1'b0, 40, lat);
        tick(20);
        chk("err_clear_no_pulse", 32'(pulses - base), 32'(1));
        chk("err_clear_idle", 32'(busy), 32'(0));
        chk("timeout_done", 32'(done_count), 32'(6));

        // No-ack: ready never goes low
        force_high = 1'b1;
        btn_mode = 1'b0;
        base = pulses;
        exp_q.push_back(1'b0);
        btn_go = 1'b0;
        wait_start_low(40, lat);
        wait_err(1'b1, 20, lat);
        chk("noack_delay_in_bound", 32'(lat >= 4 && lat <= 5), 32'(1));
        btn_go = 1'b1;
        tick(15);
        chk("noack_pulses", 32'(pulses - base), 32'(1));
        force_high = 1'b0;
        tick(3);
        press(12);
        wait_err(1'b0, 40, lat);
        tick(20);
        chk("noack_clear_idle", 32'(busy), 32'(0));
        chk("noack_done", 32'(done_count), 32'(6));

        // Reset during WAIT_RDY of the second burst command
        sw_auto = 1'b1;
        base = pulses;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        press(10);
        n = 0;
        while (pulses - base < 2 && n < 80) begin
            tick(1);
            n++;
        end
        chk("second_cmd_seen", 32'(pulses - base), 32'(2));
        tick(2);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_start", 32'(start), 32'(1));
        chk("async_rst_busy", 32'(busy), 32'(0));
        chk("async_rst_done", 32'(done_count), 32'(0));
        exp_q.delete();
        tick(2);
        rst = 1'b0;
        tick(40);
        chk("post_rst_no_pulse", 32'(pulses - base), 32'(2));
        chk("post_rst_idle", 32'(busy), 32'(0));

        base = pulses;
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b0);
        press(12);
        wait_idle(120);
        tick(15);
        chk("rerun_pulses", 32'(pulses - base), 32'(SEQ));
        chk("rerun_done", 32'(done_count), 32'(4));
        chk("rerun_queue_drained", 32'(exp_q.size()), 32'(0));
        sw_auto = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
